// File: rtl/updown_pkg.sv
// Shared types and helpers for the up/down counter.
// Optional feature macro: GRAY_OUT_EN (Gray-coded copy of the count).
package updown_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int DEF_WIDTH   = 2;
    localparam int DEF_MODULUS = 4;

    // Reflected binary Gray code; callers truncate to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/updown_next_state.sv
// Combinational next-count and wrap-flag logic for updown_counter_n.
// Priority: load > en > hold (reset is applied by the register stage).
module updown_next_state
    import updown_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULUS  = DEF_MODULUS,
    parameter bit SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] count_d_o,
    output logic             wrap_o
);

    // One spare bit so MODULUS==2**WIDTH compares and steps cleanly.
    localparam int             W1   = WIDTH + 1;
    localparam logic [W1-1:0]  LAST = W1'(MODULUS - 1);

    logic [W1-1:0] cnt_x;
    logic [W1-1:0] lv_x;
    dir_t          dir;

    assign cnt_x = {1'b0, count_i};
    assign lv_x  = {1'b0, load_value_i};
    assign dir   = dir_t'(up_i);

    // Select the next count; the wrap flag marks a range-end crossing (or a blocked step when saturating).
    always_comb begin
        count_d_o = count_i;
        wrap_o    = 1'b0;
        if (load_i) begin
            count_d_o = (lv_x > LAST) ? WIDTH'(LAST) : load_value_i;
        end else if (en_i) begin
            if (dir == DIR_UP) begin
                if (cnt_x >= LAST) begin
                    wrap_o    = 1'b1;
                    count_d_o = SATURATE ? WIDTH'(LAST) : '0;
                end else begin
                    count_d_o = WIDTH'(cnt_x + W1'(1));
                end
            end else begin
                if (cnt_x == '0) begin
                    wrap_o    = 1'b1;
                    count_d_o = SATURATE ? '0 : WIDTH'(LAST);
                end else begin
                    count_d_o = WIDTH'(cnt_x - W1'(1));
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised modulo-N up/down counter with load, enable, wrap/saturate,
// terminal-count flag and registered wrap pulse.
// Define GRAY_OUT_EN to add a registered Gray-coded copy of the count.
module updown_counter_n
    import updown_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MODULUS  = DEF_MODULUS,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrapped
`ifdef GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] count_gray
`endif
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;

    updown_next_state #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .count_i      (count_q),
        .up_i         (up),
        .en_i         (en),
        .load_i       (load),
        .load_value_i (load_value),
        .count_d_o    (count_d),
        .wrap_o       (wrapped_d)
    );

    // Count and wrap pulse registers; reset dominates everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;
    // Terminal count depends on the live direction input, not a stored one.
    assign tc      = up ? (count_q == LAST) : (count_q == '0);

`ifdef GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q;

    // Gray copy registered from the next count so it lines up with count.
    always_ff @(posedge clock) begin
        if (reset) gray_q <= '0;
        else       gray_q <= WIDTH'(bin2gray(32'(count_d)));
    end

    assign count_gray = gray_q;
`endif

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: four instances share one stimulus stream
// (2b mod4 wrap, 3b mod6 wrap, 3b mod6 saturate, 3b mod8 wrap). A behavioural
// model tracks each one and is compared every cycle; directed steps pin the
// model with literal expectations before a randomised run.
module tb_updown_counter_n;

    logic       clock = 1'b0;
    logic       reset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [2:0] lv = '0;

    logic [1:0] cnt_a;
    logic [2:0] cnt_b, cnt_c, cnt_d;
    logic       tc_a, tc_b, tc_c, tc_d;
    logic       wr_a, wr_b, wr_c, wr_d;
`ifdef GRAY_OUT_EN
    logic [1:0] gr_a;
    logic [2:0] gr_b, gr_c, gr_d;
`endif

    always #5 clock = ~clock;

    updown_counter_n #(.WIDTH(2), .MODULUS(4), .SATURATE(1'b0)) dut_a (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv[1:0]),
        .count(cnt_a), .tc(tc_a), .wrapped(wr_a)
`ifdef GRAY_OUT_EN
        , .count_gray(gr_a)
`endif
    );
    updown_counter_n #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b0)) dut_b (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv),
        .count(cnt_b), .tc(tc_b), .wrapped(wr_b)
`ifdef GRAY_OUT_EN
        , .count_gray(gr_b)
`endif
    );
    updown_counter_n #(.WIDTH(3), .MODULUS(6), .SATURATE(1'b1)) dut_c (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv),
        .count(cnt_c), .tc(tc_c), .wrapped(wr_c)
`ifdef GRAY_OUT_EN
        , .count_gray(gr_c)
`endif
    );
    updown_counter_n #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) dut_d (
        .clock(clock), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv),
        .count(cnt_d), .tc(tc_d), .wrapped(wr_d)
`ifdef GRAY_OUT_EN
        , .count_gray(gr_d)
`endif
    );

    localparam int MW[4] = '{2, 3, 3, 3};
    localparam int MM[4] = '{4, 6, 6, 8};
    localparam int MS[4] = '{0, 0, 1, 0};

    int act_c[4];
    int act_t[4];
    int act_w[4];
    assign act_c[0] = int'(cnt_a);
    assign act_c[1] = int'(cnt_b);
    assign act_c[2] = int'(cnt_c);
    assign act_c[3] = int'(cnt_d);
    assign act_t[0] = int'(tc_a);
    assign act_t[1] = int'(tc_b);
    assign act_t[2] = int'(tc_c);
    assign act_t[3] = int'(tc_d);
    assign act_w[0] = int'(wr_a);
    assign act_w[1] = int'(wr_b);
    assign act_w[2] = int'(wr_c);
    assign act_w[3] = int'(wr_d);
`ifdef GRAY_OUT_EN
    int act_g[4];
    assign act_g[0] = int'(gr_a);
    assign act_g[1] = int'(gr_b);
    assign act_g[2] = int'(gr_c);
    assign act_g[3] = int'(gr_d);
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one integer count and wrap flag per instance.
    int mc[4] = '{0, 0, 0, 0};
    int mw[4] = '{0, 0, 0, 0};
    bit mvalid = 1'b0;

    always @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            int m, v;
            m = MM[i];
            v = int'(lv) % (1 << MW[i]);
            if (reset) begin
                mc[i] = 0; mw[i] = 0;
            end else if (load) begin
                mc[i] = (v >= m) ? m - 1 : v; mw[i] = 0;
            end else if (en && up) begin
                if (mc[i] == m - 1) begin
                    mw[i] = 1;
                    if (MS[i] == 0) mc[i] = 0;
                end else begin
                    mc[i] = mc[i] + 1; mw[i] = 0;
                end
            end else if (en) begin
                if (mc[i] == 0) begin
                    mw[i] = 1;
                    if (MS[i] == 0) mc[i] = m - 1;
                end else begin
                    mc[i] = mc[i] - 1; mw[i] = 0;
                end
            end else begin
                mw[i] = 0;
            end
        end
        if (reset) mvalid = 1'b1;
    end

    // Cycle-by-cycle compare on the falling edge, once reset has been seen.
    always @(negedge clock) begin
        if (mvalid) begin
            for (int i = 0; i < 4; i++) begin
                int et;
                et = up ? int'(mc[i] == MM[i] - 1) : int'(mc[i] == 0);
                chk($sformatf("model_count%0d", i), act_c[i], mc[i]);
                chk($sformatf("model_wrap%0d", i), act_w[i], mw[i]);
                chk($sformatf("model_tc%0d", i), act_t[i], et);
`ifdef GRAY_OUT_EN
                chk($sformatf("model_gray%0d", i), act_g[i], mc[i] ^ (mc[i] >> 1));
`endif
            end
        end
    end

    // Drive one edge's worth of inputs, then return 2 time units after that edge.
    task automatic tick(input bit r, input bit l, input bit e, input bit u, input int v);
        reset = r; load = l; en = e; up = u; lv = 3'(v);
        @(posedge clock);
        #2;
    endtask

    int seq_up[5]  = '{1, 2, 3, 0, 1};
    int gray_tb[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    initial begin
        #2;
        // Reset with up=0: count 0, no wrap, tc asserted.
        tick(1, 0, 0, 0, 0);
        chk("rst_count", int'(cnt_a), 0);
        chk("rst_wrap", int'(wr_a), 0);
        chk("rst_tc_down", int'(tc_a), 1);

        // Count up five edges in mod 4.
        for (int k = 0; k < 5; k++) begin
            tick(0, 0, 1, 1, 0);
            chk($sformatf("up_count%0d", k), int'(cnt_a), seq_up[k]);
            chk($sformatf("up_wrap%0d", k), int'(wr_a), (k == 3) ? 1 : 0);
        end

        // Count down from 1: 0, 3, 2.
        tick(0, 0, 1, 0, 0);
        chk("dn_count0", int'(cnt_a), 0);
        chk("dn_tc0", int'(tc_a), 1);
        chk("dn_wrap0", int'(wr_a), 0);
        tick(0, 0, 1, 0, 0);
        chk("dn_count1", int'(cnt_a), 3);
        chk("dn_wrap1", int'(wr_a), 1);
        tick(0, 0, 1, 0, 0);
        chk("dn_count2", int'(cnt_a), 2);
        chk("dn_wrap2", int'(wr_a), 0);

        // Clamp of an out-of-range load, then wrap vs saturate at the top.
        tick(0, 1, 0, 0, 7);
        chk("clamp_b", int'(cnt_b), 5);
        chk("clamp_c", int'(cnt_c), 5);
        chk("load_a", int'(cnt_a), 3);
        chk("load_wrap", int'(wr_b), 0);
        tick(0, 0, 1, 1, 0);
        chk("wrap_b", int'(cnt_b), 0);
        chk("wrap_b_pulse", int'(wr_b), 1);
        chk("sat_c", int'(cnt_c), 5);
        chk("sat_c_pulse", int'(wr_c), 1);
        for (int k = 0; k < 2; k++) begin
            tick(0, 0, 1, 1, 0);
            chk("sat_c_hold", int'(cnt_c), 5);
            chk("sat_c_hold_pulse", int'(wr_c), 1);
        end
        tick(0, 0, 1, 0, 0);
        chk("sat_c_down", int'(cnt_c), 4);
        chk("sat_c_down_pulse", int'(wr_c), 0);

        // Priority: load beats en; reset beats load.
        tick(0, 1, 0, 0, 2);
        chk("prio_pre", int'(cnt_b), 2);
        tick(0, 1, 1, 1, 1);
        chk("prio_load", int'(cnt_b), 1);
        chk("prio_load_wrap", int'(wr_b), 0);
        tick(1, 1, 0, 0, 5);
        chk("prio_reset", int'(cnt_b), 0);
        chk("prio_reset_wrap", int'(wr_b), 0);

        // Full mod-8 lap on the 3-bit instance.
        for (int k = 0; k < 8; k++) begin
            tick(0, 0, 1, 1, 0);
            chk($sformatf("lap_count%0d", k), int'(cnt_d), (k + 1) % 8);
`ifdef GRAY_OUT_EN
            chk($sformatf("lap_gray%0d", k), int'(gr_d), gray_tb[(k + 1) % 8]);
            chk($sformatf("lap_gray_step%0d", k), $countones(3'(gray_tb[k]) ^ gr_d), 1);
`endif
        end
        chk("lap_wrap", int'(wr_d), 1);

        // Randomised run against the model.
        for (int k = 0; k < 1500; k++) begin
            tick(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)));
        end

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
